// File: rtl/control_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// legal opcode values, ALU operation classes handed to ALU control, and the
// per-class control word produced by the opcode decoder.
package control_multiciclo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ERR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  // Everything the FSM needs to know about an instruction class.
  typedef struct packed {
    logic [2:0] alu_op;     // dataUC value driven in EXEC
    logic       alu_src;    // immediate operand in EXEC
    logic       branch;     // BEQ: resolves and retires in EXEC
    logic       mem_access; // EXEC continues to MEM
    logic       mem_read;   // LW data access
    logic       mem_write;  // SW data access (retires in MEM)
    logic       reg_write;  // has a WB cycle
    logic       reg_dst;    // destination from rd field
    logic       mem_to_reg; // write-back data from memory
  } ctrl_t;

endpackage

// File: rtl/control_multiciclo_decodificador_opcode.sv
// Combinational opcode decoder.
// Ports:
//   opcode : instruction bits 31:26
//   legal  : 1 when opcode is one of the supported instructions
//   ctrl   : per-class control word (all zero for illegal opcodes)
module decodificador_opcode
  import control_multiciclo_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       legal,
  output ctrl_t      ctrl
);

  always_comb begin
    legal = 1'b1;
    ctrl  = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.alu_op    = ALU_RTYPE;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_access = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_access = 1'b1;
        ctrl.mem_write  = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle processor control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath strobes, illegal-opcode trap and retired-instruction counter.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, halt       : begin execution from IDLE / stop at next retirement
//   Opcode            : IR bits 31:26, valid from DECODE onward
//   mem_ready         : memory access completes this cycle
//   Zero              : ALU zero flag (BEQ resolution in EXEC)
//   dataUC            : ALU operation class
//   MemRead..ALUSrc   : datapath strobes and selects
//   busy, err         : running / trapped on illegal opcode
//   instr_count       : retired instructions, wraps at 2^CNT_W
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  input  logic             Zero,
  output logic [2:0]       dataUC,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state;
  logic [5:0]       op_q;
  logic [5:0]       op_dec;
  logic [CNT_W-1:0] count;
  logic             legal;
  ctrl_t            ctrl;
  logic             retire;

  // In DECODE the opcode is not latched yet, so legality is judged on the
  // live IR bits; every later state decodes the latched copy.
  assign op_dec = (state == DECODE) ? Opcode : op_q;

  decodificador_opcode u_dec (
    .opcode (op_dec),
    .legal  (legal),
    .ctrl   (ctrl)
  );

  always_comb begin
    retire = 1'b0;
    case (state)
      EXEC:    retire = ctrl.branch;
      MEM:     retire = ctrl.mem_write && mem_ready;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE:    if (start && !halt) state <= FETCH;
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          op_q  <= Opcode;
          state <= legal ? EXEC : ERR;
        end
        EXEC: begin
          if (ctrl.mem_access) state <= MEM;
          else if (!ctrl.branch) state <= WB;
        end
        MEM:     if (mem_ready && ctrl.mem_read) state <= WB;
        WB:      state <= WB;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
      // Retirement from EXEC, MEM or WB shares one exit: this assignment
      // overrides whatever the per-state branch chose above.
      if (retire) begin
        count <= count + 1'b1;
        state <= halt ? IDLE : FETCH;
      end
    end
  end

  always_comb begin
    dataUC   = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    err      = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      EXEC: begin
        dataUC = ctrl.alu_op;
        ALUSrc = ctrl.alu_src;
        if (ctrl.branch) begin
          PCWrite = Zero;
          PCSrc   = 1'b1;
        end
      end
      MEM: begin
        IorD     = 1'b1;
        MemRead  = ctrl.mem_read;
        MemWrite = ctrl.mem_write;
      end
      WB: begin
        RegWrite = ctrl.reg_write;
        RegDst   = ctrl.reg_dst;
        MemtoReg = ctrl.mem_to_reg;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  assign busy        = (state != IDLE) && (state != ERR);
  assign instr_count = count;

endmodule
